// File: rtl/pulse_stretcher_if.sv
// Strobe-in / stretched-level-out bundle for pulse_stretcher.
interface pulse_stretcher_if #(
    parameter int unsigned PEND_W = 2
);
    logic              trig;
    logic              clr_ovf;
    logic              sigOut;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output trig, clr_ovf,
        input  sigOut, busy, pending, overflow
    );

    modport slave (
        input  trig, clr_ovf,
        output sigOut, busy, pending, overflow
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Converts single-cycle strobes into fixed-length high pulses separated by a
// minimum gap; extra strobes either retrigger the pulse or queue as pending.
module pulse_stretcher #(
    parameter int unsigned WIDTH_CYC = 8,
    parameter int unsigned GAP_CYC   = 2,
    parameter int unsigned RETRIG    = 0,
    parameter int unsigned PEND_W    = 2,
    parameter int unsigned CNT_W     = 8
) (
    input logic              clk,
    input logic              rst_n,
    pulse_stretcher_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    localparam bit               RETRIG_EN = (RETRIG != 0);
    localparam logic [CNT_W-1:0] W_LOAD    = CNT_W'(WIDTH_CYC - 1);
    localparam logic [CNT_W-1:0] G_LOAD    = CNT_W'(GAP_CYC - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  timer, timer_n;
    logic [PEND_W-1:0] pend, pend_n;
    logic              ovf, ovf_n;
    logic              sig_q, busy_q;
    logic              q_inc, q_dec, ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            pend   <= '0;
            ovf    <= 1'b0;
            sig_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            pend   <= pend_n;
            ovf    <= ovf_n;
            sig_q  <= (state_n == HIGH);
            busy_q <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        q_inc   = 1'b0;
        q_dec   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.trig) begin
                    state_n = HIGH;
                    timer_n = W_LOAD;
                end
            end
            HIGH: begin
                q_inc = !RETRIG_EN && bus.trig;
                if (RETRIG_EN && bus.trig) begin
                    timer_n = W_LOAD;
                end else if (timer == '0) begin
                    state_n = GAP;
                    timer_n = G_LOAD;
                end else begin
                    timer_n = timer - CNT_W'(1);
                end
            end
            GAP: begin
                q_inc = !RETRIG_EN && bus.trig;
                if (RETRIG_EN && bus.trig) begin
                    state_n = HIGH;
                    timer_n = W_LOAD;
                end else if (timer == '0) begin
                    if (pend != '0) begin
                        state_n = HIGH;
                        timer_n = W_LOAD;
                        q_dec   = 1'b1;
                    end else begin
                        state_n = IDLE;
                        timer_n = '0;
                    end
                end else begin
                    timer_n = timer - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase

        // A trigger arriving on the dequeue edge replaces the serviced entry,
        // so it cannot overflow even when the queue is full.
        pend_n  = pend;
        ovf_set = 1'b0;
        if (q_inc && !q_dec) begin
            if (pend == '1) begin
                ovf_set = 1'b1;
            end else begin
                pend_n = pend + PEND_W'(1);
            end
        end else if (q_dec && !q_inc) begin
            pend_n = pend - PEND_W'(1);
        end

        ovf_n = ovf_set ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf);
    end

    assign bus.sigOut   = sig_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pend;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: queued instance (RETRIG=0) and retriggerable instance (RETRIG=1).
module tb_pulse_stretcher;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pulse_stretcher_if #(.PEND_W(2)) b0 ();
    pulse_stretcher_if #(.PEND_W(2)) b1 ();

    pulse_stretcher #(
        .WIDTH_CYC(8), .GAP_CYC(2), .RETRIG(0), .PEND_W(2), .CNT_W(8)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );

    pulse_stretcher #(
        .WIDTH_CYC(8), .GAP_CYC(2), .RETRIG(1), .PEND_W(2), .CNT_W(8)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n is the cycle index relative to the first trigger edge (edge 0 -> cycle 1).
    task automatic single_pulse(input string tag);
        int n;
        for (int c = 0; c < 12; c++) begin
            b0.trig = (c == 0);
            tick();
            n = c + 1;
            chk($sformatf("%s_sig_c%0d", tag, n), b0.sigOut, (n >= 1 && n <= 8));
            chk($sformatf("%s_busy_c%0d", tag, n), b0.busy, (n <= 10));
        end
        b0.trig = 1'b0;
    endtask

    initial begin
        int n;
        int rises;
        logic prev;
        int exp_pend;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        b0.trig = 1'b0; b0.clr_ovf = 1'b0;
        b1.trig = 1'b0; b1.clr_ovf = 1'b0;
        tick();
        tick();
        chk("rst_sig0", b0.sigOut, 0);
        chk("rst_busy0", b0.busy, 0);
        chk("rst_pend0", b0.pending, 0);
        chk("rst_ovf0", b0.overflow, 0);
        chk("rst_sig1", b1.sigOut, 0);
        chk("rst_busy1", b1.busy, 0);
        rst_n = 1'b1;
        tick();

        single_pulse("single");

        for (int c = 0; c < 34; c++) begin
            b0.trig = (c == 0 || c == 2 || c == 3);
            tick();
            n = c + 1;
            exp_pend = (n < 3) ? 0 : (n < 4) ? 1 : (n <= 10) ? 2 : (n <= 20) ? 1 : 0;
            chk($sformatf("queue_sig_c%0d", n), b0.sigOut,
                ((n >= 1 && n <= 8) || (n >= 11 && n <= 18) || (n >= 21 && n <= 28)));
            chk($sformatf("queue_busy_c%0d", n), b0.busy, (n <= 30));
            chk($sformatf("queue_pend_c%0d", n), b0.pending, exp_pend);
        end
        b0.trig = 1'b0;

        rises = 0;
        prev = 1'b0;
        for (int c = 0; c < 44; c++) begin
            b0.trig = (c <= 5);
            tick();
            n = c + 1;
            if (b0.sigOut && !prev) rises++;
            prev = b0.sigOut;
            if (n == 6) begin
                chk("ovf_pend_sat", b0.pending, 3);
                chk("ovf_set", b0.overflow, 1);
            end
        end
        b0.trig = 1'b0;
        chk("ovf_pulse_count", rises, 4);
        chk("ovf_idle", b0.busy, 0);
        chk("ovf_sticky", b0.overflow, 1);
        b0.clr_ovf = 1'b1;
        tick();
        b0.clr_ovf = 1'b0;
        chk("ovf_cleared", b0.overflow, 0);

        for (int c = 0; c < 13; c++) begin
            b0.trig = (c <= 3 || c == 10 || c == 12);
            b0.clr_ovf = (c == 12);
            tick();
            n = c + 1;
            if (n == 4) begin
                chk("bnd_pend_full", b0.pending, 3);
                chk("bnd_ovf_pre", b0.overflow, 0);
            end
            if (n == 11) begin
                chk("bnd_pend_exit", b0.pending, 3);
                chk("bnd_ovf_exit", b0.overflow, 0);
                chk("bnd_sig_exit", b0.sigOut, 1);
            end
            if (n == 13) begin
                chk("bnd_set_wins", b0.overflow, 1);
                chk("bnd_pend_sat", b0.pending, 3);
            end
        end
        b0.trig = 1'b0;
        b0.clr_ovf = 1'b0;
        for (int i = 0; i < 100 && b0.busy; i++) tick();
        chk("bnd_drain_busy", b0.busy, 0);
        chk("bnd_drain_pend", b0.pending, 0);
        b0.clr_ovf = 1'b1;
        tick();
        b0.clr_ovf = 1'b0;
        chk("bnd_clr", b0.overflow, 0);

        for (int c = 0; c < 4; c++) begin
            b0.trig = (c <= 2);
            tick();
        end
        b0.trig = 1'b0;
        chk("rstmid_pend_pre", b0.pending, 2);
        chk("rstmid_sig_pre", b0.sigOut, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_sig", b0.sigOut, 0);
        chk("rstmid_busy", b0.busy, 0);
        chk("rstmid_pend", b0.pending, 0);
        chk("rstmid_ovf", b0.overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();
        single_pulse("postrst");

        for (int c = 0; c < 26; c++) begin
            b1.trig = (c == 0 || c == 5 || c == 14);
            tick();
            n = c + 1;
            chk($sformatf("retrig_sig_c%0d", n), b1.sigOut,
                ((n >= 1 && n <= 13) || (n >= 15 && n <= 22)));
            chk($sformatf("retrig_busy_c%0d", n), b1.busy, (n <= 24));
            chk($sformatf("retrig_pend_c%0d", n), b1.pending, 0);
            chk($sformatf("retrig_ovf_c%0d", n), b1.overflow, 0);
        end
        b1.trig = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
